// File: rtl/spy_pkg.sv
// rtl/spy_pkg.sv - shared address map, command bits and sequencer states for the DBIR loader
package spy_pkg;

  localparam logic [1:0] SPY_DBIRL = 2'd0;
  localparam logic [1:0] SPY_DBIRM = 2'd1;
  localparam logic [1:0] SPY_DBIRH = 2'd2;
  localparam logic [1:0] SPY_CMD   = 2'd3;

  localparam int CMD_EXEC = 0;
  localparam int CMD_CLR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STEP   = 2'd2,
    ST_HOLD   = 2'd3
  } spy_state_e;

  // One-hot {H, M, L} strobe for a data address; CMD selects no register.
  function automatic logic [2:0] addr_strobe(input logic [1:0] addr);
    case (addr)
      SPY_DBIRL: return 3'b001;
      SPY_DBIRM: return 3'b010;
      SPY_DBIRH: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/spy_dbir_loader.sv
// rtl/spy_dbir_loader.sv - spy-bus writes into the debug-instruction register and debug single-step sequencer
module spy_dbir_loader
  import spy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_addr,
  input  logic [15:0] host_data,
  output logic [15:0] spy_out,
  output logic        lddbirl,
  output logic        lddbirm,
  output logic        lddbirh,
  input  logic        halted,
  output logic        idebug,
  output logic        dstep,
  output logic [2:0]  loaded,
  output logic        err,
  output logic        busy,
  output logic [7:0]  exec_cnt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  spy_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] spy_out_q, spy_out_d;
  logic [2:0]  strb_q, strb_d;
  logic [2:0]  loaded_q, loaded_d;
  logic        err_q, err_d;
  logic        idebug_q, idebug_d;
  logic        dstep_q, dstep_d;
  logic [7:0]  exec_cnt_q, exec_cnt_d;
  logic        accept;

  assign host_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = host_valid && host_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    spy_out_d  = spy_out_q;
    strb_d     = 3'b000;
    loaded_d   = loaded_q;
    err_d      = err_q;
    idebug_d   = idebug_q;
    dstep_d    = 1'b0;
    exec_cnt_d = exec_cnt_q;

    case (state_q)
      ST_IDLE: begin
        idebug_d = 1'b0;
        if (accept) begin
          if (host_addr != SPY_CMD) begin
            spy_out_d = host_data;
            strb_d    = addr_strobe(host_addr);
            loaded_d  = loaded_q | addr_strobe(host_addr);
          end else begin
            // Clear is applied before the execute check sees loaded.
            if (host_data[CMD_CLR]) begin
              loaded_d = 3'b000;
              err_d    = 1'b0;
            end
            if (host_data[CMD_EXEC]) begin
              if (loaded_d == 3'b111 && halted) begin
                state_d  = ST_SETTLE;
                cnt_d    = SETTLE_LOAD;
                idebug_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
      end

      ST_SETTLE: begin
        if (!halted) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          idebug_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_STEP;
          dstep_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_STEP: begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LOAD;
      end

      ST_HOLD: begin
        // The step is already issued, so halted no longer matters here.
        if (cnt_q == 4'd0) begin
          state_d    = ST_IDLE;
          idebug_d   = 1'b0;
          exec_cnt_d = exec_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      spy_out_q  <= 16'd0;
      strb_q     <= 3'b000;
      loaded_q   <= 3'b000;
      err_q      <= 1'b0;
      idebug_q   <= 1'b0;
      dstep_q    <= 1'b0;
      exec_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spy_out_q  <= spy_out_d;
      strb_q     <= strb_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      idebug_q   <= idebug_d;
      dstep_q    <= dstep_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  assign spy_out  = spy_out_q;
  assign lddbirl  = strb_q[0];
  assign lddbirm  = strb_q[1];
  assign lddbirh  = strb_q[2];
  assign loaded   = loaded_q;
  assign err      = err_q;
  assign idebug   = idebug_q;
  assign dstep    = dstep_q;
  assign exec_cnt = exec_cnt_q;

endmodule

// File: tb/tb_spy_dbir_loader.sv
// tb/tb_spy_dbir_loader.sv - vector table, corner sequences and randomized model checks for spy_dbir_loader
module tb_spy_dbir_loader;

  localparam int S = 2;
  localparam int H = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_addr;
  logic [15:0] host_data;
  logic [15:0] spy_out;
  logic        lddbirl, lddbirm, lddbirh;
  logic        halted;
  logic        idebug;
  logic        dstep;
  logic [2:0]  loaded;
  logic        err;
  logic        busy;
  logic [7:0]  exec_cnt;
  logic [2:0]  strb;

  always #5 clk = ~clk;

  spy_dbir_loader #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data), .spy_out(spy_out),
    .lddbirl(lddbirl), .lddbirm(lddbirm), .lddbirh(lddbirh), .halted(halted),
    .idebug(idebug), .dstep(dstep), .loaded(loaded), .err(err), .busy(busy),
    .exec_cnt(exec_cnt)
  );

  assign strb = {lddbirh, lddbirm, lddbirl};

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: what the host should observe.
  logic [2:0]  m_loaded;
  logic        m_err;
  logic [15:0] m_spy;
  logic [7:0]  m_cnt;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        halted;
    logic [2:0]  strb;
    logic [15:0] spy;
    logic [2:0]  loaded;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_loaded = 3'b000;
    m_err    = 1'b0;
    m_spy    = 16'h0000;
    m_cnt    = 8'h00;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [15:0] d, input logic h,
                             output logic [2:0] es, output bit ok);
    es = 3'b000;
    ok = 1'b0;
    if (a != 2'd3) begin
      es       = 3'(1 << a);
      m_spy    = d;
      m_loaded = m_loaded | es;
    end else begin
      if (d[1]) begin
        m_loaded = 3'b000;
        m_err    = 1'b0;
      end
      if (d[0]) begin
        if (m_loaded == 3'b111 && h) ok = 1'b1;
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic apply(input logic [1:0] a, input logic [15:0] d);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    tick();
    host_valid = 1'b0;
  endtask

  // Walks an accepted execute from its first cycle until the block is idle again.
  // drop >= 0 lowers halted during that SETTLE cycle.
  task automatic run_exec(input int drop, input bit noise);
    int last;
    last = (drop >= 0) ? drop : (S + 1 + H - 1);
    for (int t = 0; t <= last + 1; t++) begin
      if (t == last + 1) begin
        if (drop >= 0) m_err = 1'b1;
        else m_cnt = m_cnt + 8'd1;
      end
      chk("exec_idebug", idebug, (t <= last));
      chk("exec_dstep", dstep, (drop < 0 && t == S));
      chk("exec_busy", busy, (t <= last));
      chk("exec_ready", host_ready, (t > last));
      chk("exec_strobes", strb, 3'b000);
      chk("exec_spy", spy_out, m_spy);
      chk("exec_loaded", loaded, m_loaded);
      chk("exec_err", err, m_err);
      chk("exec_cnt", exec_cnt, m_cnt);
      if (t <= last) begin
        if (t == drop) halted = 1'b0;
        if (noise) begin
          host_valid = 1'($urandom_range(0, 1));
          host_addr  = 2'($urandom_range(0, 3));
          host_data  = 16'($urandom);
        end
        tick();
      end
    end
    host_valid = 1'b0;
    halted     = 1'b1;
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [15:0] d, input int drop);
    logic [2:0] es;
    bit ok;
    model_write(a, d, halted, es, ok);
    apply(a, d);
    chk("wr_strobes", strb, es);
    chk("wr_spy", spy_out, m_spy);
    chk("wr_loaded", loaded, m_loaded);
    chk("wr_err", err, m_err);
    chk("wr_busy", busy, ok);
    chk("wr_idebug", idebug, ok);
    if (ok) run_exec(drop, 1'b1);
  endtask

  task automatic idle_cycle();
    host_valid = 1'b0;
    tick();
    chk("idle_strobes", strb, 3'b000);
    chk("idle_spy_hold", spy_out, m_spy);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", host_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] es;
    bit ok;
    logic [7:0] cnt0;

    tbl[0]  = '{2'd0, 16'h1234, 1'b1, 3'b001, 16'h1234, 3'b001, 1'b0};
    tbl[1]  = '{2'd1, 16'h5678, 1'b1, 3'b010, 16'h5678, 3'b011, 1'b0};
    tbl[2]  = '{2'd3, 16'h0001, 1'b1, 3'b000, 16'h5678, 3'b011, 1'b1};
    tbl[3]  = '{2'd2, 16'h9ABC, 1'b1, 3'b100, 16'h9ABC, 3'b111, 1'b1};
    tbl[4]  = '{2'd3, 16'h0002, 1'b1, 3'b000, 16'h9ABC, 3'b000, 1'b0};
    tbl[5]  = '{2'd3, 16'h0003, 1'b1, 3'b000, 16'h9ABC, 3'b000, 1'b1};
    tbl[6]  = '{2'd3, 16'h0002, 1'b1, 3'b000, 16'h9ABC, 3'b000, 1'b0};
    tbl[7]  = '{2'd2, 16'h9ABC, 1'b1, 3'b100, 16'h9ABC, 3'b100, 1'b0};
    tbl[8]  = '{2'd1, 16'h5678, 1'b1, 3'b010, 16'h5678, 3'b110, 1'b0};
    tbl[9]  = '{2'd0, 16'h1234, 1'b1, 3'b001, 16'h1234, 3'b111, 1'b0};
    tbl[10] = '{2'd3, 16'h0001, 1'b0, 3'b000, 16'h1234, 3'b111, 1'b1};
    tbl[11] = '{2'd3, 16'hFFFC, 1'b1, 3'b000, 16'h1234, 3'b111, 1'b1};

    reset_n    = 1'b0;
    host_valid = 1'b0;
    host_addr  = 2'd0;
    host_data  = 16'h0000;
    halted     = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_spy", spy_out, 16'h0000);
    chk("rst_strobes", strb, 3'b000);
    chk("rst_idebug", idebug, 1'b0);
    chk("rst_dstep", dstep, 1'b0);
    chk("rst_loaded", loaded, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_exec_cnt", exec_cnt, 8'h00);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", host_ready, 1'b1);

    // Back-to-back table rows, none of which launches a step.
    for (int i = 0; i < 12; i++) begin
      halted = tbl[i].halted;
      model_write(tbl[i].addr, tbl[i].data, halted, es, ok);
      apply(tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_strobes", i), strb, tbl[i].strb);
      chk($sformatf("tbl%0d_spy", i), spy_out, tbl[i].spy);
      chk($sformatf("tbl%0d_loaded", i), loaded, tbl[i].loaded);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
      chk($sformatf("tbl%0d_busy", i), busy, 1'b0);
      chk($sformatf("tbl%0d_idebug", i), idebug, 1'b0);
    end
    halted = 1'b1;
    idle_cycle();

    // Clear, reload, then a default single step right after the last load.
    do_wr(2'd3, 16'h0002, -1);
    do_wr(2'd0, 16'h1234, -1);
    do_wr(2'd1, 16'h5678, -1);
    do_wr(2'd2, 16'h9ABC, -1);
    chk("seq_loaded", loaded, 3'b111);
    chk("seq_err", err, 1'b0);
    do_wr(2'd3, 16'h0001, -1);
    chk("seq_exec_cnt", exec_cnt, 8'd1);

    // Halt lost during each SETTLE cycle.
    for (int d = 0; d < S; d++) begin
      cnt0 = m_cnt;
      do_wr(2'd3, 16'h0001, d);
      chk("abort_err", err, 1'b1);
      chk("abort_cnt_same", exec_cnt, cnt0);
      do_wr(2'd3, 16'h0002, -1);
      do_wr(2'd0, 16'h0A0A, -1);
      do_wr(2'd1, 16'h0B0B, -1);
      do_wr(2'd2, 16'h0C0C, -1);
    end

    // 256 steps wrap exec_cnt back to where it started, no reload needed.
    cnt0 = m_cnt;
    for (int k = 0; k < 256; k++) begin
      do_wr(2'd3, 16'h0001, -1);
    end
    chk("wrap_exec_cnt", exec_cnt, cnt0);
    chk("wrap_loaded", loaded, 3'b111);

    // Randomized operations against the reference model.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        do_wr(2'($urandom_range(0, 2)), 16'($urandom), -1);
      end else if (r <= 8) begin
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
        halted = ($urandom_range(0, 4) != 0);
        do_wr(2'd3, d, ($urandom_range(0, 3) == 0) ? $urandom_range(0, S - 1) : -1);
        halted = 1'b1;
      end else begin
        idle_cycle();
      end
    end

    // Reset while in HOLD.
    do_wr(2'd3, 16'h0002, -1);
    do_wr(2'd0, 16'h1111, -1);
    do_wr(2'd1, 16'h2222, -1);
    do_wr(2'd2, 16'h3333, -1);
    apply(2'd3, 16'h0001);
    chk("hold_setup_busy", busy, 1'b1);
    for (int t = 0; t < S + 1; t++) tick();
    chk("hold_reached_idebug", idebug, 1'b1);
    chk("hold_reached_busy", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    model_reset();
    chk("hreset_idebug", idebug, 1'b0);
    chk("hreset_busy", busy, 1'b0);
    chk("hreset_loaded", loaded, 3'b000);
    chk("hreset_exec_cnt", exec_cnt, 8'h00);
    chk("hreset_spy", spy_out, 16'h0000);
    chk("hreset_err", err, 1'b0);
    chk("hreset_dstep", dstep, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("hreset_ready", host_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
